// File: rtl/alu_result_stage.sv
// Two-entry in-order result buffer between the ALU and MEM, with trap detection and a trap hold.
// Optional saturating signed-overflow event counter enabled by defining ALU_RESULT_OVF_COUNT_EN.
`ifndef ALU_ADD
`define ALU_ADD 5'h00
`endif
`ifndef ALU_SUB
`define ALU_SUB 5'h02
`endif

module alu_result_stage #(
   parameter int unsigned COUNT_W = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_opt,
   input  logic [31:0] in_result,
   input  logic        in_zero,
   input  logic        in_negative,
   input  logic        in_carry,
   input  logic [4:0]  in_dest,
   input  logic        in_trap_en,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [4:0]  out_dest,
   output logic        out_zero,
   output logic        out_negative,
   output logic        out_trap
`ifdef ALU_RESULT_OVF_COUNT_EN
  ,output logic [COUNT_W-1:0] ovf_count
`endif
);

   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO, S_HOLD} state_e;

   typedef struct packed {
      logic [31:0] result;
      logic [4:0]  dest;
      logic        zero;
      logic        negative;
      logic        trap;
   } entry_t;

   state_e     state_q, state_d;
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] vld_q, vld_d;
   logic       in_ready_q, in_ready_d;
   entry_t     entry_q [2];
   entry_t     entry_d [2];
   entry_t     out_entry;

   logic is_addsub, trap_in, accept, deliver;

   assign is_addsub = (in_opt == `ALU_ADD) || (in_opt == `ALU_SUB);
   assign trap_in   = in_carry && in_trap_en && is_addsub;
   assign accept    = in_valid && in_ready_q;
   assign out_valid = vld_q[rd_ptr_q];
   assign deliver   = out_valid && out_ready;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      vld_d    = vld_q;
      entry_d  = entry_q;
      if (flush) begin
         state_d  = S_EMPTY;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         vld_d    = '0;
      end else begin
         if (deliver) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + 1'b1;
         end
         if (accept) begin
            entry_d[wr_ptr_q].result   = in_result;
            entry_d[wr_ptr_q].dest     = trap_in ? 5'd0 : in_dest;
            entry_d[wr_ptr_q].zero     = in_zero;
            entry_d[wr_ptr_q].negative = in_negative;
            entry_d[wr_ptr_q].trap     = trap_in;
            vld_d[wr_ptr_q]            = 1'b1;
            wr_ptr_d                   = wr_ptr_q + 1'b1;
         end
         // HOLD is sticky until flush; otherwise the state mirrors occupancy
         if ((state_q == S_HOLD) || (accept && trap_in)) begin
            state_d = S_HOLD;
         end else begin
            case (vld_d)
               2'b00:   state_d = S_EMPTY;
               2'b11:   state_d = S_TWO;
               default: state_d = S_ONE;
            endcase
         end
      end
      in_ready_d = (state_d == S_EMPTY) || (state_d == S_ONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_EMPTY;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         vld_q      <= '0;
         in_ready_q <= 1'b0;
         entry_q    <= '{default: '0};
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         vld_q      <= vld_d;
         in_ready_q <= in_ready_d;
         entry_q    <= entry_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign out_entry    = out_valid ? entry_q[rd_ptr_q] : '0;
   assign out_result   = out_entry.result;
   assign out_dest     = out_entry.dest;
   assign out_zero     = out_entry.zero;
   assign out_negative = out_entry.negative;
   assign out_trap     = out_entry.trap;

`ifdef ALU_RESULT_OVF_COUNT_EN
   logic [COUNT_W-1:0] ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (!flush && accept && in_carry && is_addsub && (ovf_q != '1))
         ovf_d = ovf_q + COUNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovf_q <= '0;
      else        ovf_q <= ovf_d;
   end

   assign ovf_count = ovf_q;
`else
   // COUNT_W only sizes the counter; keep it referenced when the counter is compiled out
   logic unused_count_w;
   assign unused_count_w = (COUNT_W > 0);
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage; overflow-counter checks follow ALU_RESULT_OVF_COUNT_EN.
`ifndef ALU_ADD
`define ALU_ADD 5'h00
`endif
`ifndef ALU_ADDU
`define ALU_ADDU 5'h01
`endif
`ifndef ALU_SUB
`define ALU_SUB 5'h02
`endif
`ifndef ALU_MULT
`define ALU_MULT 5'h08
`endif

module tb_alu_result_stage;
   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready;
   logic [4:0]  in_opt, in_dest, out_dest;
   logic [31:0] in_result, out_result;
   logic        in_zero, in_negative, in_carry, in_trap_en;
   logic        out_valid, out_ready, out_zero, out_negative, out_trap;
`ifdef ALU_RESULT_OVF_COUNT_EN
   logic [15:0] ovf_count;
`endif
   int checks = 0;
   int errors = 0;

   alu_result_stage #(.COUNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_opt(in_opt), .in_result(in_result), .in_zero(in_zero), .in_negative(in_negative),
      .in_carry(in_carry), .in_dest(in_dest), .in_trap_en(in_trap_en),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_dest(out_dest),
      .out_zero(out_zero), .out_negative(out_negative), .out_trap(out_trap)
`ifdef ALU_RESULT_OVF_COUNT_EN
     ,.ovf_count(ovf_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] res, input logic [4:0] dst,
                        input logic cy, input logic ten, input logic neg, input logic zr);
      in_valid = v; in_opt = op; in_result = res; in_dest = dst;
      in_carry = cy; in_trap_en = ten; in_negative = neg; in_zero = zr;
   endtask

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, `ALU_ADD, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if ({out_result, out_dest, out_zero, out_negative, out_trap} !== 40'h0)
         begin errors++; $display("FAIL reset_outputs got %h/%h/%b%b%b exp all 0", out_result, out_dest, out_zero, out_negative, out_trap); end
`ifdef ALU_RESULT_OVF_COUNT_EN
      checks++; if (ovf_count !== 16'd0) begin errors++; $display("FAIL reset_ovf got %0d exp 0", ovf_count); end
`endif
      #6 rst_n = 1'b1;
      tick;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_single;
      out_ready = 1'b1;
      drive(1'b1, `ALU_ADD, 32'h5, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      tick;
      drive(1'b0, `ALU_ADD, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
      checks++; if (out_result !== 32'h5) begin errors++; $display("FAIL single_result got %h exp 00000005", out_result); end
      checks++; if (out_dest !== 5'd3) begin errors++; $display("FAIL single_dest got %0d exp 3", out_dest); end
      checks++; if (out_trap !== 1'b0) begin errors++; $display("FAIL single_trap got %b exp 0", out_trap); end
      tick;
      checks++; if (out_valid !== 1'b0 || out_result !== 32'h0 || out_dest !== 5'd0)
         begin errors++; $display("FAIL single_drained got v=%b r=%h d=%0d exp 0/0/0", out_valid, out_result, out_dest); end
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b0;
      drive(1'b1, `ALU_ADDU, 32'h11, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_one got %b exp 1", in_ready); end
      drive(1'b1, `ALU_ADDU, 32'h22, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      tick;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_two got %b exp 0", in_ready); end
      drive(1'b1, `ALU_ADDU, 32'h33, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1);
      tick;
      checks++; if (out_valid !== 1'b1 || out_result !== 32'h11 || out_dest !== 5'd1)
         begin errors++; $display("FAIL b2b_stall_head got v=%b r=%h d=%0d exp 1/11/1", out_valid, out_result, out_dest); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_third_blocked got %b exp 0", in_ready); end
      drive(1'b0, `ALU_ADD, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      out_ready = 1'b1;
      tick;
      checks++; if (out_valid !== 1'b1 || out_result !== 32'h22 || out_dest !== 5'd2 || out_negative !== 1'b1)
         begin errors++; $display("FAIL b2b_second got v=%b r=%h d=%0d n=%b exp 1/22/2/1", out_valid, out_result, out_dest, out_negative); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_deliver got %b exp 1", in_ready); end
      tick;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_third got %b exp 0", out_valid); end
   endtask

   task automatic test_trap;
      out_ready = 1'b0;
      drive(1'b1, `ALU_ADD, 32'h8000_0000, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
      tick;
      drive(1'b1, `ALU_ADDU, 32'h44, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_trap !== 1'b1 || out_dest !== 5'd0)
         begin errors++; $display("FAIL trap_entry got v=%b t=%b d=%0d exp 1/1/0", out_valid, out_trap, out_dest); end
      checks++; if (out_result !== 32'h8000_0000 || out_negative !== 1'b1)
         begin errors++; $display("FAIL trap_result got r=%h n=%b exp 80000000/1", out_result, out_negative); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL trap_hold_ready got %b exp 0", in_ready); end
      out_ready = 1'b1;
      tick;
      tick;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0)
         begin errors++; $display("FAIL trap_hold_drained got v=%b rdy=%b exp 0/0", out_valid, in_ready); end
`ifdef ALU_RESULT_OVF_COUNT_EN
      checks++; if (ovf_count !== 16'd1) begin errors++; $display("FAIL trap_ovf got %0d exp 1", ovf_count); end
`endif
      drive(1'b0, `ALU_ADD, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      flush = 1'b1;
      tick;
      flush = 1'b0;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
         begin errors++; $display("FAIL trap_flush got rdy=%b v=%b exp 1/0", in_ready, out_valid); end
   endtask

   task automatic test_flush;
      out_ready = 1'b0;
      drive(1'b1, `ALU_ADDU, 32'h55, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      tick;
      drive(1'b1, `ALU_ADDU, 32'h66, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
      tick;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_setup_two got %b exp 0", in_ready); end
      drive(1'b1, `ALU_ADD, 32'h77, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      out_ready = 1'b1;
      flush = 1'b1;
      tick;
      flush = 1'b0;
      drive(1'b0, `ALU_ADD, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h0)
         begin errors++; $display("FAIL flush_empty got v=%b rdy=%b r=%h exp 0/1/0", out_valid, in_ready, out_result); end
      tick;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_nothing_after got %b exp 0", out_valid); end
`ifdef ALU_RESULT_OVF_COUNT_EN
      checks++; if (ovf_count !== 16'd1) begin errors++; $display("FAIL flush_ovf_blocked got %0d exp 1", ovf_count); end
`endif
   endtask

   task automatic test_midreset;
      out_ready = 1'b0;
      drive(1'b1, `ALU_ADD, 32'h88, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
      tick;
      drive(1'b1, `ALU_ADDU, 32'h99, 5'd11, 1'b0, 1'b0, 1'b0, 1'b0);
      tick;
      drive(1'b0, `ALU_ADD, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
         begin errors++; $display("FAIL midrst_setup got v=%b rdy=%b exp 1/0", out_valid, in_ready); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_result !== 32'h0)
         begin errors++; $display("FAIL midrst_async got v=%b rdy=%b r=%h exp 0/0/0", out_valid, in_ready, out_result); end
      tick;
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      tick;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
         begin errors++; $display("FAIL midrst_release got rdy=%b v=%b exp 1/0", in_ready, out_valid); end
`ifdef ALU_RESULT_OVF_COUNT_EN
      checks++; if (ovf_count !== 16'd0) begin errors++; $display("FAIL midrst_ovf got %0d exp 0", ovf_count); end
`endif
      tick;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stays_empty got %b exp 0", out_valid); end
   endtask

   task automatic test_nontrap;
      out_ready = 1'b1;
      drive(1'b1, `ALU_SUB, 32'h7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      tick;
      drive(1'b1, `ALU_MULT, 32'h9, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
      checks++; if (out_valid !== 1'b1 || out_trap !== 1'b0 || out_dest !== 5'd5)
         begin errors++; $display("FAIL nontrap_sub got v=%b t=%b d=%0d exp 1/0/5", out_valid, out_trap, out_dest); end
      tick;
      drive(1'b0, `ALU_ADD, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_trap !== 1'b0 || out_dest !== 5'd6 || out_result !== 32'h9 || out_zero !== 1'b1)
         begin errors++; $display("FAIL nontrap_mult got v=%b t=%b d=%0d r=%h z=%b exp 1/0/6/9/1", out_valid, out_trap, out_dest, out_result, out_zero); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nontrap_ready got %b exp 1", in_ready); end
      tick;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nontrap_drained got %b exp 0", out_valid); end
`ifdef ALU_RESULT_OVF_COUNT_EN
      checks++; if (ovf_count !== 16'd1) begin errors++; $display("FAIL nontrap_ovf got %0d exp 1", ovf_count); end
`endif
   endtask

   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_trap;
      test_flush;
      test_midreset;
      test_nontrap;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
